// File: rtl/int_gateway_bank.sv
// rtl/int_gateway_bank.sv - interrupt gateway bank: per-source sync, gateway FSM, claim/complete

module int_gateway_bank #(
  parameter  int N_SRC       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(N_SRC + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_SRC-1:0]  io_int_in,
  input  logic [N_SRC-1:0]  io_enable,
  input  logic              io_claim_req,
  output logic [ID_W-1:0]   io_claim_id,
  output logic              io_irq,
  input  logic              io_complete_valid,
  input  logic [ID_W-1:0]   io_complete_id,
  output logic [N_SRC-1:0]  io_pending,
  output logic [N_SRC-1:0]  io_inflight
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_INFLIGHT = 2'd2
  } gw_state_e;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_line;

  gw_state_e        state_q [N_SRC];
  gw_state_e        state_d [N_SRC];

  logic [ID_W-1:0]  claim_id_q, claim_id_d;
  logic             irq_q, irq_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] inflight_q, inflight_d;

  assign sync_line = sync_q[SYNC_STAGES-1];

  // Synchronizer chain bringing the asynchronous crossbar lines into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= io_int_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Gateway state register, one FSM per source
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SRC; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Gateway next-state: claim only hits the source currently shown, complete only hits an in-flight one
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (sync_line[i]) state_d[i] = ST_PENDING;
        end
        ST_PENDING: begin
          if (io_claim_req && (claim_id_q == ID_W'(i + 1))) state_d[i] = ST_INFLIGHT;
        end
        ST_INFLIGHT: begin
          if (io_complete_valid && (io_complete_id == ID_W'(i + 1))) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Output decode from next-state so a just-claimed source is never offered again
  always_comb begin
    claim_id_d = '0;
    pending_d  = '0;
    inflight_d = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      pending_d[i]  = (state_d[i] == ST_PENDING);
      inflight_d[i] = (state_d[i] == ST_INFLIGHT);
      if ((state_d[i] == ST_PENDING) && io_enable[i]) begin
        claim_id_d = ID_W'(i + 1);
      end
    end
    irq_d = (claim_id_d != '0);
  end

  // Registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      claim_id_q <= '0;
      irq_q      <= 1'b0;
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      claim_id_q <= claim_id_d;
      irq_q      <= irq_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  assign io_claim_id = claim_id_q;
  assign io_irq      = irq_q;
  assign io_pending  = pending_q;
  assign io_inflight = inflight_q;

endmodule

// File: doc/int_gateway_bank.md
# int_gateway_bank

Interrupt gateway bank that sits directly downstream of the interrupt crossbar. It takes the flat vector of level-sensitive interrupt lines the crossbar produces, synchronizes each line into the local clock domain, and runs a per-source gateway state machine (idle / pending / in-flight). It presents the highest-priority enabled pending source to a single consumer through a claim/complete handshake, so each interrupt assertion is delivered exactly once until it is completed.

## Interface
- N_SRC, 4: number of interrupt sources (1..31); source IDs are 1..N_SRC, ID 0 means "none".
- SYNC_STAGES, 2: synchronizer flop depth per source (>= 2).
- ID_W, $clog2(N_SRC+1): width of ID fields (derived, not overridable).

- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- io_int_in  input  N_SRC  level interrupt lines from the crossbar; bit i is source ID i+1; asynchronous to clock.
- io_enable  input  N_SRC  per-source enable; bit i gates selection of source ID i+1.
- io_claim_req  input  1  claim strobe; claims the source shown on io_claim_id this cycle.
- io_claim_id  output  ID_W  registered ID of the best enabled pending source; 0 if none.
- io_irq  output  1  registered; equals (io_claim_id != 0).
- io_complete_valid  input  1  completion strobe.
- io_complete_id  input  ID_W  ID being completed.
- io_pending  output  N_SRC  registered; bit i = source i+1 in PENDING.
- io_inflight  output  N_SRC  registered; bit i = source i+1 in INFLIGHT.

## Operation
- Synchronizer: per-bit SYNC_STAGES flop chain, reset to 0; output sync[i] feeds the gateway only.
- Gateway FSM per source, states IDLE, PENDING, INFLIGHT (reset: IDLE).
  - IDLE -> PENDING when sync[i]=1.
  - PENDING -> INFLIGHT when io_claim_req=1 and io_claim_id == i+1.
  - INFLIGHT -> IDLE when io_complete_valid=1 and io_complete_id == i+1.
  - All other cases hold. While PENDING or INFLIGHT, sync[i] is ignored (no re-trigger, no count).
  - After INFLIGHT -> IDLE, a still-high sync[i] re-enters PENDING on the following edge.
- Selection: next claim_id = lowest ID whose next-state is PENDING and whose io_enable bit is 1; 0 if none. Computing from next-state guarantees back-to-back claims never return the same ID twice.
- Disabled sources still advance IDLE -> PENDING; they are only excluded from selection. Enabling a pending source makes it visible after one edge.
- Ignored events (no state change, no error): io_claim_req while io_claim_id == 0; complete with ID 0, ID > N_SRC, or a source not in INFLIGHT.
- Claim and complete in the same cycle act independently; each touches at most one source. Claim and complete of the same source in the same cycle is impossible (PENDING vs INFLIGHT), so complete is ignored.

## Timing
- Reset values: io_claim_id=0, io_irq=0, io_pending=0, io_inflight=0, all sync flops 0.
- Reset asserted mid-operation: all in-flight and pending state is lost immediately. Completes issued after reset are ignored. Sources still high re-pend SYNC_STAGES+1 edges after reset deasserts.
- Latency: io_int_in bit high and sampled at edge k -> io_pending bit and io_claim_id/io_irq valid after edge k+SYNC_STAGES.
- Claim at edge j: io_inflight set and io_claim_id advanced to the next candidate (or 0) after edge j. The consumer samples io_claim_id in the same cycle it asserts io_claim_req.
- Complete at edge j: io_inflight bit clears after edge j. A still-high line is PENDING and selectable after edge j+1.
- Throughput: one claim and one complete per cycle.
- Input pulses shorter than one clock period may be missed; lines are level-held by sources.

## Test plan
- Reset/idle: assert reset mid-run with source 2 INFLIGHT -> all outputs 0 immediately. complete_id=2 after release is ignored, and io_inflight stays 0.
- Latency: N_SRC=4, SYNC_STAGES=2, enable=4'hF, raise io_int_in[2] before edge 10 -> io_claim_id=3 and io_irq=1 after edge 12, not before.
- Priority/back-to-back: io_int_in=4'b1010 held, all enabled. Claim on two consecutive cycles -> IDs 2 then 4, then io_claim_id=0 and io_inflight=4'b1010.
- Enable masking: source 1 pending, enable=4'b1110 -> io_claim_id=0 and io_pending[0]=1. Set enable[0]=1 -> io_claim_id=1 after one edge.
- Re-trigger: claim source 3 with line held high, complete 3 -> io_inflight[2] clears, io_claim_id=3 one edge later. With the line low instead, source 3 stays IDLE.
- Illegal events: complete_id=0, complete_id=5, complete of a PENDING source, and claim with io_claim_id=0 -> no change in io_pending or io_inflight.
